shift_deserializer: RTL
=======================

# shift_deserializer

Serial-to-parallel receive stage that consumes the MSB-first bit stream produced by the team's parallel-load shift register and reassembles it into `BITWIDTH`-bit words. Each word is presented on a val/rdy output interface through a one-entry holding buffer. Words that arrive while the buffer is still full are dropped, and a sticky overflow flag records the drop. It sits directly downstream of the serializer, either on-chip or across a pin-level link.

## Interface
- `BITWIDTH`, 32: word width in bits; legal range ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `in`  in  1  serial data bit, sampled only when `shift_en` = 1.
- `shift_en`  in  1  bit strobe; one bit is captured per cycle in which it is high.
- `sync`  in  1  word-boundary resync; discards any partial word.
- `out_msg`  out  `BITWIDTH`  assembled word, MSB = first bit received.
- `out_val`  out  1  `out_msg` is valid.
- `out_rdy`  in  1  consumer accepts the word when `out_val` & `out_rdy`.
- `out_perr`  out  1  parity error for the word on `out_msg`; qualified by `out_val`.
- `overflow`  out  1  sticky: at least one completed word was dropped.

## Operation
- Datapath: shift register `shreg` (`BITWIDTH`-1 bits) plus bit counter `cnt`, width `$clog2(BITWIDTH+2)`.
- States:
  - COLLECT: `cnt` < `BITWIDTH`.
  - PARITY: `cnt` == `BITWIDTH`; reached only when the parity feature is compiled in.
- Strobe in COLLECT with `cnt` < `BITWIDTH`-1: `shreg` <= {`shreg`[`BITWIDTH`-3:0], `in`}, `cnt`++.
- Final data strobe (`cnt` == `BITWIDTH`-1): assembled word = {`shreg`, `in`}.
  - Parity feature out: word completes now; `cnt` <= 0.
  - Parity feature in: word is latched into a staging register; `cnt` <= `BITWIDTH`.
- Word complete:
  - Buffer empty, or drained this cycle (`out_val` & `out_rdy`): load the buffer; `out_val` <= 1.
  - Otherwise: word dropped, buffer contents unchanged, `overflow` <= 1.
- Buffer drain (`out_val` & `out_rdy`) with no simultaneous load: `out_val` <= 0.
- `sync` = 1: `cnt` <= 0 and the partial word is discarded.
  - If `shift_en` is also 1 that cycle, `in` is captured as bit 0 of the new word (`cnt` <= 1).
  - `sync` never affects the output buffer or `overflow`.
- `out_msg` and `out_perr` hold stable while `out_val` = 1 and `out_rdy` = 0.

## Timing
- Reset values: `out_val` = 0, `out_msg` = 0, `out_perr` = 0, `overflow` = 0, `cnt` = 0, `shreg` = 0.
- `reset` takes priority over all inputs. Reset mid-word discards the partial word and any buffered word.
- Latency: `out_val` rises the cycle after the completing strobe.
- Throughput: one word per `BITWIDTH` strobes, plus one strobe with the parity feature. Back-to-back strobes on consecutive cycles are legal.
- With `out_rdy` tied high, no word is ever dropped.
- `out_val` does not depend combinationally on `out_rdy`. All outputs are registered.

## Configuration
- Macro `SHIFT_DESER_PARITY_EN`.
- Defined:
  - One extra strobe follows each data word, carrying an even-parity bit over the word's `BITWIDTH` data bits.
  - The word completes on the parity strobe.
  - `out_perr` = 1 when the XOR of the data bits and the parity bit is 1.
- Undefined:
  - The PARITY state is absent and no extra strobe is expected.
  - `out_perr` is tied to 0.

## Structure
- Package `shift_deser_pkg`: state enum {COLLECT, PARITY}; localparam helper for the counter width.
- Sub-module `deser_outbuf`:
  - One-entry val/rdy holding register with a load/drop decision and the `overflow` flag.
  - Parameterised on payload width (`BITWIDTH`+1, carrying `out_perr`).
- Top level contains the counter, `shreg`, the parity accumulator and the sync logic.

## Test plan
- Reset, then `BITWIDTH`=8 stream 1,0,1,0,0,1,0,1 with `out_rdy`=1 → one cycle after the last strobe, `out_val`=1 and `out_msg`=8'hA5; `out_val` drops the next cycle.
- Two words 8'h3C and 8'hFF back-to-back with `out_rdy`=0 → `out_msg` stays 8'h3C and `overflow`=1; raise `out_rdy` → 8'h3C is accepted and 8'hFF is never presented.
- Send 5 bits, pulse `sync` together with a strobe, then send the rest of 8'h81 → `out_msg`=8'h81; the partial bits do not appear.
- Word completes in the same cycle that `out_val`&`out_rdy` drains the previous word → new word is loaded and `out_val` stays 1; `overflow` stays 0.
- Assert `reset` after 4 bits of a word, then send 8'h5A → `out_msg`=8'h5A, `overflow`=0.
- With `SHIFT_DESER_PARITY_EN` defined, send 8'h07 with parity bit 1 → `out_perr`=0; send 8'h07 with parity bit 0 → `out_perr`=1.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and helpers for the shift_deserializer receive stage.
//   state_t   : COLLECT while data bits are arriving, PARITY while waiting
//               for the trailing parity strobe (parity builds only).
//   cnt_width : bit-counter width able to hold 0..BITWIDTH+1.
package shift_deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  function automatic int cnt_width(input int bw);
    return $clog2(bw + 2);
  endfunction

endpackage

// File: rtl/deser_outbuf.sv
// One-entry val/rdy holding buffer for completed words.
//   clk, reset : clock, synchronous active-high reset
//   load, data : a completed word is offered this cycle
//   rdy        : consumer accepts msg when val & rdy
//   val, msg   : registered buffer contents
//   overflow   : sticky, set when an offered word could not be loaded
module deser_outbuf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         rdy,
  output logic         val,
  output logic [W-1:0] msg,
  output logic         overflow
);

  logic drain;
  logic accept;

  assign drain  = val & rdy;
  // A word may replace an entry that is leaving this very cycle.
  assign accept = load & (~val | rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      val      <= 1'b0;
      msg      <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        msg <= data;
        val <= 1'b1;
      end else if (drain) begin
        val <= 1'b0;
      end
      if (load && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receive stage for an MSB-first bit stream.
// Optional feature macro: SHIFT_DESER_PARITY_EN (adds a trailing even-parity
// strobe per word and drives out_perr).
//   clk, reset : clock, synchronous active-high reset
//   in         : serial bit, sampled when shift_en = 1
//   shift_en   : bit strobe
//   sync       : word-boundary resync, discards any partial word
//   out_msg    : assembled word, MSB = first bit received
//   out_val    : out_msg valid
//   out_rdy    : consumer accepts when out_val & out_rdy
//   out_perr   : parity error for out_msg (0 when parity is compiled out)
//   overflow   : sticky, a completed word was dropped
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in,
  input  logic                shift_en,
  input  logic                sync,
  output logic [BITWIDTH-1:0] out_msg,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                out_perr,
  output logic                overflow
);

  localparam int CW = cnt_width(BITWIDTH);
  localparam logic [CW-1:0] LAST = CW'(BITWIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(BITWIDTH);

  logic [BITWIDTH-2:0] shreg, shreg_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [BITWIDTH-1:0] assembled;
  logic [BITWIDTH-1:0] word;
  logic                word_done;
  logic                perr;
  state_t              state;

`ifdef SHIFT_DESER_PARITY_EN
  logic [BITWIDTH-1:0] stage, stage_nxt;
`endif

  // The counter itself is the state register; PARITY is the one count
  // beyond the data bits.
  assign state     = (cnt == FULL) ? PARITY : COLLECT;
  assign assembled = {shreg, in};

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      shreg <= '0;
`ifdef SHIFT_DESER_PARITY_EN
      stage <= '0;
`endif
    end else begin
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
`ifdef SHIFT_DESER_PARITY_EN
      stage <= stage_nxt;
`endif
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    word_done = 1'b0;
    word      = assembled;
    perr      = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
    stage_nxt = stage;
`endif
    if (sync) begin
      // A strobe coinciding with sync is bit 0 of the fresh word.
      cnt_nxt   = shift_en ? CW'(1) : '0;
      shreg_nxt = shift_en ? (BITWIDTH-1)'(in) : '0;
    end else if (shift_en) begin
      unique case (state)
        COLLECT: begin
          if (cnt == LAST) begin
            shreg_nxt = '0;
`ifdef SHIFT_DESER_PARITY_EN
            stage_nxt = assembled;
            cnt_nxt   = FULL;
`else
            word_done = 1'b1;
            cnt_nxt   = '0;
`endif
          end else begin
            shreg_nxt = assembled[BITWIDTH-2:0];
            cnt_nxt   = cnt + CW'(1);
          end
        end
        PARITY: begin
`ifdef SHIFT_DESER_PARITY_EN
          word_done = 1'b1;
          word      = stage;
          perr      = ^{stage, in};
          cnt_nxt   = '0;
`endif
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  deser_outbuf #(
    .W(BITWIDTH + 1)
  ) u_outbuf (
    .clk      (clk),
    .reset    (reset),
    .load     (word_done),
    .data     ({perr, word}),
    .rdy      (out_rdy),
    .val      (out_val),
    .msg      ({out_perr, out_msg}),
    .overflow (overflow)
  );

endmodule
